// File: rtl/latency_monitor_pkg.sv
// Shared defaults and pointer sizing for the latency monitor and its timestamp FIFO.
package latency_monitor_pkg;
   localparam int DEFAULT_COUNTER_WIDTH   = 16;
   localparam int DEFAULT_MAX_OUTSTANDING = 4;

   // Index width into a FIFO of the given depth; the pointers carry one extra wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/timestamp_fifo.sv
// In-order timestamp FIFO: single clock, synchronous reset, wrap-bit pointers for full/empty.
module timestamp_fifo
   import latency_monitor_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter  int DEPTH = DEFAULT_MAX_OUTSTANDING,
   localparam int PW    = ptr_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
   end

endmodule

// File: rtl/latency_monitor.sv
// Measures marker-to-feedback latency in cycles against a free-running timestamp.
module latency_monitor
   import latency_monitor_pkg::*;
#(
   parameter int COUNTER_WIDTH   = DEFAULT_COUNTER_WIDTH,
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             marker_signal,
   input  logic                             feedback_signal,
   output logic [COUNTER_WIDTH-1:0]         latency_out,
   output logic                             latency_valid,
   output logic [COUNTER_WIDTH-1:0]         max_latency,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                             overflow_err,
   output logic                             underflow_err
);

   localparam int PW = ptr_width(MAX_OUTSTANDING);

   logic [COUNTER_WIDTH-1:0] ts_q, ts_d;
   logic [COUNTER_WIDTH-1:0] lat_q, lat_d;
   logic [COUNTER_WIDTH-1:0] max_q, max_d;
   logic                     valid_q, valid_d;
   logic                     ovf_q, ovf_d;
   logic                     unf_q, unf_d;

   logic [COUNTER_WIDTH-1:0] head;
   logic                     fifo_full, fifo_empty;
   logic                     push_en, pop_en;
   logic [PW:0]              fifo_count;

   // marker/feedback are one-cycle event strobes with no backpressure: every asserted
   // cycle is one event, and whatever cannot be accepted is flagged via the sticky errors.
   assign pop_en  = feedback_signal && !fifo_empty;
   assign push_en = marker_signal && !(fifo_empty && feedback_signal)
                    && (!fifo_full || feedback_signal);

   timestamp_fifo #(
      .WIDTH (COUNTER_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push_en),
      .pop_i   (pop_en),
      .data_i  (ts_q),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      ts_d    = ts_q + 1'b1;
      valid_d = 1'b0;
      lat_d   = lat_q;
      max_d   = max_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (feedback_signal && !fifo_empty) begin
         valid_d = 1'b1;
         lat_d   = ts_q - head;
      end else if (feedback_signal && marker_signal) begin
         // Marker and feedback collide on an empty FIFO: zero-cycle round trip.
         valid_d = 1'b1;
         lat_d   = '0;
      end
      if (valid_d && (lat_d > max_q)) max_d = lat_d;
      if (marker_signal && !feedback_signal && fifo_full)    ovf_d = 1'b1;
      if (feedback_signal && !marker_signal && fifo_empty)   unf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q    <= '0;
         lat_q   <= '0;
         valid_q <= 1'b0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         ts_q    <= ts_d;
         lat_q   <= lat_d;
         valid_q <= valid_d;
         max_q   <= max_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign latency_out   = lat_q;
   assign latency_valid = valid_q;
   assign max_latency   = max_q;
   assign outstanding   = fifo_count;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

endmodule

// File: tb/tb_latency_monitor.sv
// Directed bench for latency_monitor: default instance plus a 4-bit counter instance for wrap cases.
module tb_latency_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        marker_signal = 1'b0;
   logic        feedback_signal = 1'b0;

   logic [15:0] latency_out, max_latency;
   logic        latency_valid, overflow_err, underflow_err;
   logic [2:0]  outstanding;

   logic [3:0]  latency_out4, max_latency4;
   logic        latency_valid4, overflow_err4, underflow_err4;
   logic [2:0]  outstanding4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   latency_monitor dut (
      .clk             (clk),
      .rst             (rst),
      .marker_signal   (marker_signal),
      .feedback_signal (feedback_signal),
      .latency_out     (latency_out),
      .latency_valid   (latency_valid),
      .max_latency     (max_latency),
      .outstanding     (outstanding),
      .overflow_err    (overflow_err),
      .underflow_err   (underflow_err)
   );

   latency_monitor #(.COUNTER_WIDTH(4), .MAX_OUTSTANDING(4)) dut4 (
      .clk             (clk),
      .rst             (rst),
      .marker_signal   (marker_signal),
      .feedback_signal (feedback_signal),
      .latency_out     (latency_out4),
      .latency_valid   (latency_valid4),
      .max_latency     (max_latency4),
      .outstanding     (outstanding4),
      .overflow_err    (overflow_err4),
      .underflow_err   (underflow_err4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive strobes, let the edge sample them, then settle before checking.
   task automatic cyc(input logic m, input logic f);
      marker_signal   = m;
      feedback_signal = f;
      @(posedge clk);
      #1;
      marker_signal   = 1'b0;
      feedback_signal = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      marker_signal   = 1'b0;
      feedback_signal = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_lat"},   32'(latency_out),   0);
      chk({tag, "_valid"}, 32'(latency_valid), 0);
      chk({tag, "_max"},   32'(max_latency),   0);
      chk({tag, "_outst"}, 32'(outstanding),   0);
      chk({tag, "_ovf"},   32'(overflow_err),  0);
      chk({tag, "_unf"},   32'(underflow_err), 0);
   endtask

   initial begin
      #2;
      // Basic measurement: marker at cycle 10, feedback at cycle 17.
      do_reset();
      chk_zero("rst");
      idle(10);
      cyc(1'b1, 1'b0);
      chk("basic_outst1", 32'(outstanding), 1);
      idle(6);
      cyc(1'b0, 1'b1);
      chk("basic_valid", 32'(latency_valid), 1);
      chk("basic_lat",   32'(latency_out),   7);
      chk("basic_max",   32'(max_latency),   7);
      chk("basic_outst0", 32'(outstanding),  0);
      cyc(1'b0, 1'b0);
      chk("basic_pulse", 32'(latency_valid), 0);

      // Fill, overflow, drain.
      do_reset();
      idle(5);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
      chk("fill_outst", 32'(outstanding), 4);
      chk("fill_no_ovf", 32'(overflow_err), 0);
      cyc(1'b1, 1'b0);
      chk("ovf_flag",  32'(overflow_err), 1);
      chk("ovf_outst", 32'(outstanding),  4);
      idle(10);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1);
         chk("drain_valid", 32'(latency_valid), 1);
         chk("drain_lat",   32'(latency_out),   15);
      end
      chk("drain_outst", 32'(outstanding),  0);
      chk("drain_max",   32'(max_latency),  15);
      chk("drain_ovf",   32'(overflow_err), 1);
      chk("drain_unf",   32'(underflow_err), 0);

      // Simultaneous marker+feedback while full.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
      idle(2);
      cyc(1'b1, 1'b1);
      chk("fullboth_valid", 32'(latency_valid), 1);
      chk("fullboth_lat",   32'(latency_out),   6);
      chk("fullboth_outst", 32'(outstanding),   4);
      chk("fullboth_ovf",   32'(overflow_err),  0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1);
         chk("fullboth_drain", 32'(latency_out), 6);
      end
      cyc(1'b0, 1'b1);
      chk("fullboth_last", 32'(latency_out), 4);
      chk("fullboth_empty", 32'(outstanding), 0);

      // Underflow, then same-cycle marker+feedback on empty.
      do_reset();
      cyc(1'b0, 1'b1);
      chk("unf_valid", 32'(latency_valid), 0);
      chk("unf_flag",  32'(underflow_err), 1);
      chk("unf_outst", 32'(outstanding),   0);
      do_reset();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      chk("pre_lat", 32'(latency_out), 1);
      cyc(1'b1, 1'b1);
      chk("emptyboth_valid", 32'(latency_valid), 1);
      chk("emptyboth_lat",   32'(latency_out),   0);
      chk("emptyboth_outst", 32'(outstanding),   0);
      chk("emptyboth_unf",   32'(underflow_err), 0);
      chk("emptyboth_ovf",   32'(overflow_err),  0);

      // Narrow counter wrap: marker at timestamp 14, feedback at timestamp 3.
      do_reset();
      idle(14);
      cyc(1'b1, 1'b0);
      idle(4);
      cyc(1'b0, 1'b1);
      chk("wrap4_valid", 32'(latency_valid4), 1);
      chk("wrap4_lat",   32'(latency_out4),   5);
      chk("wrap16_lat",  32'(latency_out),    5);
      cyc(1'b1, 1'b0);
      idle(19);
      cyc(1'b0, 1'b1);
      chk("mod4_lat",  32'(latency_out4), 4);
      chk("mod16_lat", 32'(latency_out),  20);
      chk("mod4_max",  32'(max_latency4), 5);
      chk("mod16_max", 32'(max_latency),  20);

      // Reset mid-measurement discards outstanding timestamps and sticky flags.
      do_reset();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("mid_pre_unf", 32'(underflow_err), 1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("mid_outst2", 32'(outstanding), 2);
      do_reset();
      chk_zero("mid_rst");
      cyc(1'b0, 1'b1);
      chk("mid_unf",   32'(underflow_err), 1);
      chk("mid_valid", 32'(latency_valid), 0);
      chk("mid_outst", 32'(outstanding),   0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/latency_monitor.md
LATENCY_MONITOR -- requirements
Module: latency_monitor

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16: width of the timestamp counter and of reported latency.
REQ-002 Parameter MAX_OUTSTANDING, default 4 (power of two, >=2): number of markers that may await feedback.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port marker_signal, input, 1: request issued this cycle; one timestamp per asserted cycle.
REQ-006 Port feedback_signal, input, 1: response completed this cycle; retires the oldest outstanding marker.
REQ-007 Port latency_out, output, COUNTER_WIDTH: measured cycles from marker to matching feedback.
REQ-008 Port latency_valid, output, 1: latency_out valid this cycle (single-cycle pulse).
REQ-009 Port max_latency, output, COUNTER_WIDTH: largest latency reported since reset.
REQ-010 Port outstanding, output, $clog2(MAX_OUTSTANDING)+1: current count of unretired markers.
REQ-011 Port overflow_err, output, 1: sticky; set when a marker arrives while full and no feedback is retiring.
REQ-012 Port underflow_err, output, 1: sticky; set when feedback arrives while empty and no marker is present.

Function
REQ-013 A free-running COUNTER_WIDTH timestamp counter SHALL increment by 1 every cycle and wrap modulo 2^COUNTER_WIDTH.
REQ-014 A marker SHALL push the current timestamp into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-015 A feedback SHALL pop the FIFO head and compute latency = (timestamp_now - head) modulo 2^COUNTER_WIDTH.
REQ-016 latency_out/latency_valid SHALL be registered: presented the cycle after the feedback cycle (1-cycle latency).
REQ-017 Marker at cycle N, feedback at cycle N+k SHALL report k; true latencies >= 2^COUNTER_WIDTH are reported modulo.
REQ-018 Marker and feedback in the same cycle with FIFO non-empty: pop head for the report and push the new timestamp; occupancy unchanged.
REQ-019 Marker and feedback in the same cycle with FIFO empty: report latency 0, no push, no error.
REQ-020 Marker and feedback in the same cycle with FIFO full: pop and push both succeed; overflow_err not set.
REQ-021 Marker alone while full: timestamp dropped, overflow_err set, FIFO contents unchanged.
REQ-022 Feedback alone while empty: no report (latency_valid stays 0), underflow_err set.
REQ-023 max_latency SHALL update to latency_out in the same cycle latency_valid is asserted, when the new value is larger.
REQ-024 outstanding SHALL equal pushes minus pops and never exceed MAX_OUTSTANDING.
REQ-025 FIFO read/write pointers SHALL wrap modulo MAX_OUTSTANDING, with an extra bit to distinguish full from empty.

Reset
REQ-026 While rst is high at a clock edge, the following SHALL be cleared to 0: timestamp counter, FIFO pointers, outstanding, latency_out, latency_valid, max_latency, overflow_err and underflow_err.
REQ-027 Reset asserted mid-measurement SHALL discard all outstanding timestamps; a following feedback with no marker is an underflow.
REQ-028 Error flags SHALL clear only on reset.

Structure
REQ-029 Shared package latency_monitor_pkg SHALL hold default COUNTER_WIDTH and MAX_OUTSTANDING, and a pointer-width helper constant/function.
REQ-030 The FIFO SHALL be a sub-module timestamp_fifo (sync, single clock, push/pop/full/empty/count); latency arithmetic, max tracking and errors stay in latency_monitor.
REQ-031 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-032 Reset, marker at cycle 10, feedback at cycle 17 -> latency_valid at cycle 18 with latency_out=7, max_latency=7, outstanding back to 0.
REQ-033 Markers at cycles 5,6,7,8 (full, outstanding=4), then marker at 9 alone -> overflow_err=1; feedbacks at 20-23 report 15,15,15,15.
REQ-034 Feedback with empty FIFO -> underflow_err=1, no latency_valid; same-cycle marker+feedback on empty -> latency 0 reported, no error.
REQ-035 COUNTER_WIDTH=4, marker at timestamp 14, feedback 5 cycles later (timestamp 3) -> latency_out=5.
REQ-036 Full FIFO with marker+feedback in the same cycle -> head latency reported, outstanding stays 4, overflow_err=0.
REQ-037 Two markers outstanding, rst pulsed 1 cycle -> all outputs 0; next lone feedback -> underflow_err=1.
